// File: rtl/ps2_tx.sv
// PS/2 host-to-device transmitter: request-to-send, then start/data/parity/stop on device clock edges, then ACK check.
// Latency: RTS_CYCLES of ps2c low, then 12 filtered device clock falls; tx_done_tick one cycle after the last fall or timeout.
// Backpressure: wr_ps2 is taken only while tx_idle=1; strobes during a transfer are dropped.
`timescale 1ns/1ps
module ps2_tx #(
   parameter int RTS_CYCLES     = 13000,
   parameter int TIMEOUT_CYCLES = 2000000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       wr_ps2,
   input  logic [7:0] din,
   inout  wire        ps2c,
   inout  wire        ps2d,
   output logic       tx_idle,
   output logic       tx_done_tick,
   output logic       tx_err
);

   localparam int RTS_W = (RTS_CYCLES > 2) ? $clog2(RTS_CYCLES) : 1;
   localparam int WD_W  = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

   localparam logic [RTS_W-1:0] RTS_RELOAD = RTS_W'(RTS_CYCLES - 1);
   localparam logic [WD_W-1:0]  WD_RELOAD  = WD_W'(TIMEOUT_CYCLES - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_RTS,
      S_START,
      S_DATA,
      S_STOP,
      S_ACK
   } state_t;

   state_t            state;
   logic [7:0]        filter_reg;
   logic [7:0]        filter_next;
   logic              f_ps2c_reg;
   logic              f_ps2c_next;
   logic              fall_edge;
   logic [1:0]        d_sync;
   logic [8:0]        b_reg;
   logic [3:0]        n_reg;
   logic [RTS_W-1:0]  rts_cnt;
   logic [WD_W-1:0]   wd_cnt;
   logic              wd_active;
   logic              c_en;
   logic              d_en;

   // Open-drain line drivers: pull low or release, never drive high.
   assign ps2c = c_en ? 1'b0 : 1'bz;
   assign ps2d = d_en ? 1'b0 : 1'bz;

   assign tx_idle = (state == S_IDLE);

   // Glitch filter on ps2c: level only flips after 8 identical samples.
   always_comb begin
      filter_next = {ps2c, filter_reg[7:1]};
      f_ps2c_next = f_ps2c_reg;
      if (filter_next == 8'hFF)
         f_ps2c_next = 1'b1;
      else if (filter_next == 8'h00)
         f_ps2c_next = 1'b0;
      fall_edge = f_ps2c_reg & ~f_ps2c_next;
   end

   // Watchdog runs only while waiting on the device clock.
   always_comb begin
      wd_active = (state == S_START) || (state == S_DATA) ||
                  (state == S_STOP)  || (state == S_ACK);
   end

   // Filter history and filtered clock level.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         filter_reg <= 8'hFF;
         f_ps2c_reg <= 1'b1;
      end else begin
         filter_reg <= filter_next;
         f_ps2c_reg <= f_ps2c_next;
      end
   end

   // Two-flop synchroniser for ps2d; only the ACK slot looks at it.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         d_sync <= 2'b11;
      else
         d_sync <= {d_sync[0], ps2d};
   end

   // Transfer FSM with registered line enables, done pulse and error flag.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state        <= S_IDLE;
         b_reg        <= '0;
         n_reg        <= '0;
         rts_cnt      <= '0;
         wd_cnt       <= '0;
         c_en         <= 1'b0;
         d_en         <= 1'b0;
         tx_done_tick <= 1'b0;
         tx_err       <= 1'b0;
      end else begin
         tx_done_tick <= 1'b0;
         if (wd_active && !fall_edge && (wd_cnt == '0)) begin
            // Device went quiet: abandon the byte and report it.
            c_en         <= 1'b0;
            d_en         <= 1'b0;
            tx_err       <= 1'b1;
            tx_done_tick <= 1'b1;
            state        <= S_IDLE;
         end else begin
            if (wd_active)
               wd_cnt <= fall_edge ? WD_RELOAD : (wd_cnt - WD_W'(1));
            case (state)
               S_IDLE: begin
                  c_en <= 1'b0;
                  d_en <= 1'b0;
                  if (wr_ps2) begin
                     b_reg   <= {~^din, din};
                     rts_cnt <= RTS_RELOAD;
                     tx_err  <= 1'b0;
                     c_en    <= 1'b1;
                     state   <= S_RTS;
                  end
               end
               S_RTS: begin
                  if (rts_cnt == '0) begin
                     // Release the clock and present the start bit together.
                     c_en   <= 1'b0;
                     d_en   <= 1'b1;
                     wd_cnt <= WD_RELOAD;
                     state  <= S_START;
                  end else begin
                     rts_cnt <= rts_cnt - RTS_W'(1);
                  end
               end
               S_START: begin
                  if (fall_edge) begin
                     n_reg <= 4'd8;
                     d_en  <= ~b_reg[0];
                     state <= S_DATA;
                  end
               end
               S_DATA: begin
                  if (fall_edge) begin
                     b_reg <= {1'b0, b_reg[8:1]};
                     if (n_reg == 4'd0) begin
                        d_en  <= 1'b0;
                        state <= S_STOP;
                     end else begin
                        n_reg <= n_reg - 4'd1;
                        d_en  <= ~b_reg[1];
                     end
                  end
               end
               S_STOP: begin
                  if (fall_edge)
                     state <= S_ACK;
               end
               S_ACK: begin
                  if (fall_edge) begin
                     tx_err       <= d_sync[1];
                     tx_done_tick <= 1'b1;
                     state        <= S_IDLE;
                  end
               end
               default: begin
                  c_en  <= 1'b0;
                  d_en  <= 1'b0;
                  state <= S_IDLE;
               end
            endcase
         end
      end
   end

endmodule

// File: doc/ps2_tx.md
Name: ps2_tx

Overview:
- PS/2 host-to-device transmitter.
- Sends one command byte (e.g. 0xED set-LEDs, 0xFF reset) from the FPGA to the keyboard over the shared ps2c/ps2d lines. It is the counterpart of the existing ps2_rx receiver.
- Drives both lines open-drain (low or released). It performs request-to-send, shifts out data and parity on device-generated clock edges, and checks the device acknowledge.
- tx_idle feeds ps2_rx.rx_en in the top level, so the receiver is disabled while a byte goes out.

Parameters:
- RTS_CYCLES, 13000, clk cycles ps2c is held low for request-to-send (130 us at 100 MHz; must be at least 100 us).
- TIMEOUT_CYCLES, 2000000, max clk cycles between consecutive filtered ps2c falling edges after RTS before the transfer is aborted (20 ms).

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous active-low reset
- wr_ps2  in  1  one-cycle start strobe; accepted only when tx_idle=1
- din  in  8  byte to send, sampled on the accepted wr_ps2 cycle
- ps2c  inout  1  PS/2 clock; driven 0 or high-Z, never driven 1
- ps2d  inout  1  PS/2 data; driven 0 or high-Z, never driven 1
- tx_idle  out  1  1 when the FSM is in idle
- tx_done_tick  out  1  one-cycle pulse at the end of every transfer (success or failure)
- tx_err  out  1  1 if the last transfer was NACKed or timed out; cleared on the next accepted wr_ps2

Behaviour:
- Reset (reset=0, asynchronous):
  - state=idle; both tri-state enables 0, so lines are released in the same cycle.
  - tx_idle=1, tx_done_tick=0, tx_err=0.
  - Filter register=8'hFF, filtered ps2c=1, ps2d synchroniser=2'b11.
- Clock filter:
  - ps2c is shifted into an 8-bit register every clk.
  - Filtered value goes to 1 when all 8 samples are 1 and to 0 when all 8 are 0; otherwise it holds.
  - fall_edge = filtered_reg & ~filtered_next. Glitches shorter than 8 cycles produce no edge.
- ps2d input: passed through a 2-flop synchroniser, used only for ACK sampling.
- Shift register: 9 bits, b = {parity, din}, where parity = ~^din (odd parity). Bit counter n is 4 bits.
- Watchdog: counts in states start, data, stop and ack. It reloads to TIMEOUT_CYCLES-1 on entry to start and on every fall_edge.
- FSM:
  - idle:
    - Lines released.
    - On wr_ps2: load b, load RTS counter to RTS_CYCLES-1, clear tx_err, go to rts.
  - rts:
    - Drive ps2c=0; ps2d released.
    - Count down; at 0 go to start. Total low time is exactly RTS_CYCLES cycles.
  - start:
    - Release ps2c; drive ps2d=0 (start bit).
    - On fall_edge: n=8, go to data.
  - data:
    - Drive ps2d low when b[0]=0, release when b[0]=1.
    - On fall_edge: b shifts right. If n=0 go to stop, else n=n-1. This sends 8 data bits LSB first, then parity.
  - stop:
    - Release ps2d (stop bit = 1).
    - On fall_edge go to ack.
  - ack:
    - Both lines released.
    - On fall_edge: tx_err = synchronised ps2d (0 = ACK, 1 = NACK), pulse tx_done_tick, go to idle.
- Timeout:
  - If the watchdog reaches 0 in start, data, stop or ack: release lines, set tx_err=1, pulse tx_done_tick, go to idle.
  - The watchdog is never active in rts or idle.
- Busy rules:
  - wr_ps2 while tx_idle=0 is ignored; din changes mid-transfer have no effect.
  - fall_edge while idle is ignored (device-to-host traffic).
- Timing:
  - tx_done_tick is asserted the cycle after the terminating fall_edge or timeout.
  - tx_idle returns to 1 in that same cycle.
  - A new wr_ps2 is accepted in that same cycle.
- Reset asserted mid-transfer: lines released immediately, no tx_done_tick, FSM in idle after release.

Test Plan:
Bench setup: RTS_CYCLES=20, TIMEOUT_CYCLES=2000, plus a device model that clocks ps2c at a 100-clk period after detecting RTS and samples ps2d on rising edges.
1. wr_ps2 with din=0xED:
   - ps2c low for exactly 20 cycles.
   - Model sees start 0, data 1,0,1,1,0,1,1,1, parity 1, stop 1.
   - Model ACKs with 0. Expect tx_done_tick for one cycle, tx_err=0, tx_idle=1.
2. Parity check:
   - din=0x00 → parity 1.
   - din=0xFF → parity 1.
   - din=0x01 → parity 0.
   - In each case the model verifies 11 sampled bits.
3. NACK: model leaves ps2d high on the ack edge → tx_done_tick with tx_err=1; the next wr_ps2 clears tx_err.
4. Timeout: model never clocks after RTS → 2000 cycles after entering start, tx_done_tick, tx_err=1, both lines high-Z.
5. Busy and reset:
   - A second wr_ps2 with din=0x55 mid-transfer is ignored; the original byte completes.
   - reset=0 asserted during the data state → ps2c/ps2d high-Z in the same cycle, tx_idle=1, no tx_done_tick.
6. Glitch immunity: inject a 3-cycle low pulse on ps2c during the data state → no bit shift. Transfer completes with correct bits.
